pic_ack_sequencer: RTL and testbench

- Clocked interrupt-acknowledge sequencer for the 8259 PIC.
- Resolves priority among pending requests against in-service levels, raises INT and owns the in-service register (ISR).
- Runs the two-pulse INTA handshake and drives the call vector on the second pulse.
- Sits between the IRR/mask datapath and the control-word register block, consuming its mask, rotation, EOI and AEOI configuration.

---
 rtl/pic_pkg.sv | 25 ++
 rtl/pic_ack_sequencer_if.sv | 37 +++
 rtl/pic_priority_resolver.sv | 26 ++
 rtl/pic_ack_sequencer.sv | 133 +++++++++++++
 tb/tb_pic_ack_sequencer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259 interrupt-acknowledge sequencer.
package pic_pkg;

    localparam int unsigned NUM_IR = 8;
    localparam int unsigned ID_W = 3;
    localparam logic [ID_W-1:0] FULLY_NESTED = 3'd7;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StAck1,
        StWait2,
        StAck2
    } state_e;

    function automatic logic [ID_W-1:0] onehot_to_id(input logic [NUM_IR-1:0] oh);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = 0; i < NUM_IR; i++) begin
            if (oh[i]) id = id | ID_W'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/pic_ack_sequencer_if.sv
// Configuration, request and CPU handshake signals of the acknowledge sequencer.
interface pic_ack_sequencer_if;
    import pic_pkg::*;

    logic [NUM_IR-1:0] irr;
    logic [NUM_IR-1:0] int_mask;
    logic [ID_W-1:0]   priority_rotate;
    logic [4:0]        vector_base;
    logic              auto_eoi;
    logic [NUM_IR-1:0] eoi;
    logic              write_icw1;
    logic              int_ack_n;

    logic              int_out;
    logic [NUM_IR-1:0] isr;
    logic [NUM_IR-1:0] highest_level_in_service;
    logic [NUM_IR-1:0] clear_irr;
    logic [NUM_IR-1:0] acknowledge_interrupt;
    logic              end_of_ack_seq;
    logic [7:0]        data_out;
    logic              data_out_en;

    modport master (
        output irr, int_mask, priority_rotate, vector_base, auto_eoi, eoi, write_icw1,
               int_ack_n,
        input  int_out, isr, highest_level_in_service, clear_irr, acknowledge_interrupt,
               end_of_ack_seq, data_out, data_out_en
    );

    modport slave (
        input  irr, int_mask, priority_rotate, vector_base, auto_eoi, eoi, write_icw1,
               int_ack_n,
        output int_out, isr, highest_level_in_service, clear_irr, acknowledge_interrupt,
               end_of_ack_seq, data_out, data_out_en
    );

endinterface

// File: rtl/pic_priority_resolver.sv
// Picks the highest-priority set bit; priority starts at rotate+1 and wraps down to rotate.
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [NUM_IR-1:0] req,
    input  logic [ID_W-1:0]   rotate,
    output logic [NUM_IR-1:0] onehot
);

    logic [ID_W-1:0] lvl;
    logic            found;

    always_comb begin
        onehot = '0;
        found  = 1'b0;
        lvl    = '0;
        for (int i = 0; i < NUM_IR; i++) begin
            lvl = rotate + 3'd1 + ID_W'(i);  // 3-bit wrap gives the cyclic order
            if (!found && req[lvl]) begin
                onehot[lvl] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pic_ack_sequencer.sv
// 8259 acknowledge sequencer: priority arbitration, INT, ISR ownership and the two-pulse INTA.
module pic_ack_sequencer
    import pic_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SPURIOUS_ID = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    pic_ack_sequencer_if.slave bus
);

    localparam logic [NUM_IR-1:0] SpuriousOh = NUM_IR'(1) << SPURIOUS_ID;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_prev_q;
    logic                   ack_sync, fall, rise;

    state_e            state_q, state_d;
    logic [NUM_IR-1:0] winner_q, winner_d;
    logic              spurious_q, spurious_d;
    logic [NUM_IR-1:0] isr_q, isr_d;
    logic [NUM_IR-1:0] clear_irr_q, clear_irr_d;
    logic [NUM_IR-1:0] set_mask, aeoi_clr;
    logic              eoa;

    logic [NUM_IR-1:0] cand_oh, hlis_oh;
    logic [ID_W-1:0]   rot_hi, cand_rank, hlis_rank;
    logic              cand_valid;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], bus.int_ack_n};
    assign ack_sync = sync_q[SYNC_STAGES-1];
    assign fall     = sync_prev_q & ~ack_sync;
    assign rise     = ~sync_prev_q & ack_sync;

    pic_priority_resolver u_req_res (
        .req    (bus.irr & ~bus.int_mask),
        .rotate (bus.priority_rotate),
        .onehot (cand_oh)
    );

    pic_priority_resolver u_isr_res (
        .req    (isr_q),
        .rotate (bus.priority_rotate),
        .onehot (hlis_oh)
    );

    // Rank 0 is the highest priority level under the current rotation.
    assign rot_hi     = bus.priority_rotate + 3'd1;
    assign cand_rank  = onehot_to_id(cand_oh) - rot_hi;
    assign hlis_rank  = onehot_to_id(hlis_oh) - rot_hi;
    assign cand_valid = (|cand_oh) && (~|isr_q || (cand_rank < hlis_rank));

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        spurious_d  = spurious_q;
        set_mask    = '0;
        aeoi_clr    = '0;
        clear_irr_d = '0;
        eoa         = 1'b0;
        unique case (state_q)
            StIdle: if (cand_valid) state_d = StReq;
            StReq: begin
                if (fall) begin
                    state_d = StAck1;
                    if (cand_valid) begin
                        winner_d    = cand_oh;
                        spurious_d  = 1'b0;
                        set_mask    = cand_oh;
                        clear_irr_d = cand_oh;
                    end else begin
                        winner_d   = SpuriousOh;
                        spurious_d = 1'b1;
                    end
                end else if (!cand_valid) begin
                    state_d = StIdle;
                end
            end
            StAck1:  if (rise) state_d = StWait2;
            StWait2: if (fall) state_d = StAck2;
            StAck2: begin
                if (rise) begin
                    state_d = StIdle;
                    eoa     = 1'b1;
                    if (bus.auto_eoi && !spurious_q) aeoi_clr = winner_q;
                end
            end
            default: state_d = StIdle;
        endcase
        isr_d = (isr_q & ~bus.eoi & ~aeoi_clr) | set_mask;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= '1;
            sync_prev_q <= 1'b1;
            state_q     <= StIdle;
            winner_q    <= '0;
            spurious_q  <= 1'b0;
            isr_q       <= '0;
            clear_irr_q <= '0;
        end else if (bus.write_icw1) begin
            sync_q      <= '1;
            sync_prev_q <= 1'b1;
            state_q     <= StIdle;
            winner_q    <= '0;
            spurious_q  <= 1'b0;
            isr_q       <= '0;
            clear_irr_q <= '0;
        end else begin
            sync_q      <= sync_d;
            sync_prev_q <= ack_sync;
            state_q     <= state_d;
            winner_q    <= winner_d;
            spurious_q  <= spurious_d;
            isr_q       <= isr_d;
            clear_irr_q <= clear_irr_d;
        end
    end

    // Derived from async-reset state so the bus is released the moment reset_n falls.
    assign bus.data_out_en = (state_q == StAck2) && !ack_sync;
    assign bus.data_out    = bus.data_out_en ? {bus.vector_base, onehot_to_id(winner_q)} : '0;

    assign bus.int_out                  = (state_q == StReq);
    assign bus.isr                      = isr_q;
    assign bus.highest_level_in_service = hlis_oh;
    assign bus.clear_irr                = clear_irr_q;
    assign bus.acknowledge_interrupt    = winner_q;
    assign bus.end_of_ack_seq           = eoa;

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Directed bench for pic_ack_sequencer; a negedge monitor scores clear_irr, vectors and ISR at EOA.
module tb_pic_ack_sequencer;
    import pic_pkg::*;

    localparam int unsigned SyncStages = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    pic_ack_sequencer_if bus ();

    pic_ack_sequencer #(
        .SYNC_STAGES (SyncStages),
        .SPURIOUS_ID (7)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_clr_q[$];
    logic [7:0] exp_vec_q[$];
    logic [7:0] exp_eoa_q[$];
    logic       en_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.clear_irr != 8'h00) begin
            if (exp_clr_q.size() == 0) check("clear_irr unexpected", 64'(bus.clear_irr), 64'h0);
            else check("clear_irr pulse", 64'(bus.clear_irr), 64'(exp_clr_q.pop_front()));
        end
        if (bus.data_out_en && !en_prev) begin
            if (exp_vec_q.size() == 0) check("vector unexpected", 64'(bus.data_out), 64'h0);
            else check("vector byte", 64'(bus.data_out), 64'(exp_vec_q.pop_front()));
        end
        if (bus.end_of_ack_seq) begin
            if (exp_eoa_q.size() == 0) check("eoa unexpected", 64'(bus.isr), 64'hFFFF);
            else check("isr at eoa", 64'(bus.isr), 64'(exp_eoa_q.pop_front()));
        end
        en_prev <= bus.data_out_en;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic inta_low();
        bus.int_ack_n = 1'b0;
        cyc(4);
    endtask

    task automatic inta_high();
        bus.int_ack_n = 1'b1;
        cyc(4);
    endtask

    // Two INTA pulses; the requester drops its IRR bit after the first one.
    task automatic full_ack(input logic [7:0] drop);
        inta_low();
        bus.irr = bus.irr & ~drop;
        inta_high();
        inta_low();
        inta_high();
    endtask

    task automatic expect_seq(input logic [7:0] clr, input logic [7:0] vec, input logic [7:0] eoa_isr);
        if (clr != 8'h00) exp_clr_q.push_back(clr);
        exp_vec_q.push_back(vec);
        exp_eoa_q.push_back(eoa_isr);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.int_out, bus.isr, bus.highest_level_in_service, bus.clear_irr,
                    bus.acknowledge_interrupt, bus.end_of_ack_seq, bus.data_out,
                    bus.data_out_en});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.irr = 8'h00;
        bus.int_mask = 8'h00;
        bus.priority_rotate = FULLY_NESTED;
        bus.vector_base = 5'b10100;
        bus.auto_eoi = 1'b0;
        bus.eoi = 8'h00;
        bus.write_icw1 = 1'b0;
        bus.int_ack_n = 1'b1;
        #12;
        check("reset outputs", all_outs(), 64'h0);
        reset_n = 1'b1;
        cyc(2);

        // Basic fully nested sequence on IR3
        bus.irr = 8'h08;
        cyc(1);
        check("int_out latency", 64'(bus.int_out), 64'h1);
        expect_seq(8'h08, 8'hA3, 8'h08);
        inta_low();
        bus.irr = 8'h00;
        inta_high();
        check("ack latched IR3", 64'(bus.acknowledge_interrupt), 64'h08);
        check("isr set IR3", 64'(bus.isr), 64'h08);
        inta_low();
        inta_high();
        check("hlis IR3", 64'(bus.highest_level_in_service), 64'h08);
        bus.eoi = 8'h08;
        cyc(1);
        bus.eoi = 8'h00;
        check("eoi clears IR3", 64'(bus.isr), 64'h00);

        // Lower request blocked by in-service IR2 until EOI
        bus.irr = 8'h04;
        cyc(1);
        check("int_out IR2", 64'(bus.int_out), 64'h1);
        expect_seq(8'h04, 8'hA2, 8'h04);
        full_ack(8'h04);
        check("isr IR2", 64'(bus.isr), 64'h04);
        bus.irr = 8'h10;
        cyc(5);
        check("IR4 blocked by IR2", 64'(bus.int_out), 64'h0);
        bus.eoi = 8'h04;
        cyc(1);
        bus.eoi = 8'h00;
        check("int_out after eoi edge", 64'(bus.int_out), 64'h0);
        cyc(1);
        check("int_out after eoi", 64'(bus.int_out), 64'h1);
        expect_seq(8'h10, 8'hA4, 8'h10);
        full_ack(8'h10);
        bus.eoi = 8'h10;
        cyc(1);
        bus.eoi = 8'h00;

        // Masking the candidate in REQ drops INT
        bus.irr = 8'h08;
        cyc(1);
        check("int_out before mask", 64'(bus.int_out), 64'h1);
        bus.int_mask = 8'h08;
        cyc(1);
        check("int_out after mask", 64'(bus.int_out), 64'h0);
        bus.irr = 8'h00;
        bus.int_mask = 8'h00;
        cyc(2);

        // Spurious: IR1 withdrawn exactly as the first fall is seen
        bus.irr = 8'h02;
        cyc(1);
        check("int_out IR1", 64'(bus.int_out), 64'h1);
        expect_seq(8'h00, 8'hA7, 8'h00);
        bus.int_ack_n = 1'b0;
        cyc(SyncStages);
        bus.irr = 8'h00;
        cyc(4 - SyncStages);
        inta_high();
        check("spurious isr", 64'(bus.isr), 64'h00);
        check("spurious ack id", 64'(bus.acknowledge_interrupt), 64'h80);
        inta_low();
        inta_high();
        check("spurious isr after", 64'(bus.isr), 64'h00);

        // Rotation: lowest = IR2, so order 3..7,0,1,2 and IR7 beats IR0
        bus.priority_rotate = 3'd2;
        bus.irr = 8'h81;
        cyc(1);
        check("int_out rotate", 64'(bus.int_out), 64'h1);
        expect_seq(8'h80, 8'hA7, 8'h80);
        full_ack(8'h80);
        check("ack rotate IR7", 64'(bus.acknowledge_interrupt), 64'h80);
        check("hlis rotate", 64'(bus.highest_level_in_service), 64'h80);
        cyc(2);
        check("IR0 blocked by IR7", 64'(bus.int_out), 64'h0);
        bus.irr = 8'h00;
        bus.eoi = 8'h80;
        cyc(1);
        bus.eoi = 8'h00;
        bus.priority_rotate = FULLY_NESTED;
        check("isr after rotate eoi", 64'(bus.isr), 64'h00);

        // Auto-EOI
        bus.auto_eoi = 1'b1;
        bus.irr = 8'h01;
        cyc(1);
        check("int_out IR0", 64'(bus.int_out), 64'h1);
        expect_seq(8'h01, 8'hA0, 8'h01);
        full_ack(8'h01);
        check("aeoi cleared", 64'(bus.isr), 64'h00);
        bus.auto_eoi = 1'b0;

        // Reset in WAIT2, then a fresh sequence
        bus.irr = 8'h40;
        cyc(1);
        check("int_out IR6", 64'(bus.int_out), 64'h1);
        exp_clr_q.push_back(8'h40);
        inta_low();
        bus.irr = 8'h00;
        inta_high();
        check("isr IR6 in wait2", 64'(bus.isr), 64'h40);
        #3;
        reset_n = 1'b0;
        #1;
        check("async reset outputs", all_outs(), 64'h0);
        cyc(1);
        reset_n = 1'b1;
        cyc(1);
        bus.irr = 8'h20;
        cyc(1);
        check("int_out IR5", 64'(bus.int_out), 64'h1);
        expect_seq(8'h20, 8'hA5, 8'h20);
        full_ack(8'h20);
        check("isr IR5", 64'(bus.isr), 64'h20);
        bus.write_icw1 = 1'b1;
        cyc(1);
        bus.write_icw1 = 1'b0;
        check("icw1 clears isr", 64'(bus.isr), 64'h00);

        cyc(3);
        check("clr queue drained", 64'(exp_clr_q.size()), 64'h0);
        check("vec queue drained", 64'(exp_vec_q.size()), 64'h0);
        check("eoa queue drained", 64'(exp_eoa_q.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
